// File: rtl/fa_serial_8.sv
// ---------------------------------------------------------------------------
// fa_serial_8 : multi-cycle digit-serial adder.
//
// Computes a + b + cin over NDIG = DATA_WIDTH/DIGIT_WIDTH clock cycles. Each
// cycle adds one DIGIT_WIDTH-wide digit, starting from the least significant
// one. A carry register links consecutive digits. The adder trades latency
// for area.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous reset, active-low
//   in_valid   operands a, b, cin are valid
//   in_ready   block can accept operands (IDLE only, and only out of reset)
//   a, b       augend / addend, DATA_WIDTH bits
//   cin        carry into digit 0
//   out_valid  sum/cout/ovf/zero are valid; held until out_ready
//   out_ready  consumer accepts the result
//   sum        (a + b + cin) mod 2^DATA_WIDTH
//   cout       carry out of the MSB
//   ovf        two's-complement overflow (carry into MSB ^ carry out of MSB)
//   zero       sum == 0
// ---------------------------------------------------------------------------
module fa_serial_8 #(
    parameter int DATA_WIDTH  = 8,
    parameter int DIGIT_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  cin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] sum,
    output logic                  cout,
    output logic                  ovf,
    output logic                  zero
);

    localparam int NDIG = DATA_WIDTH / DIGIT_WIDTH;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST_DIG = CW'(NDIG - 1);

    // The digit width must tile the operand exactly.
    if ((DATA_WIDTH % DIGIT_WIDTH) != 0) begin : g_bad_digit_width
        $error("fa_serial_8: DIGIT_WIDTH must divide DATA_WIDTH exactly");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [DATA_WIDTH-1:0]  r_a_sh;
    logic [DATA_WIDTH-1:0]  r_b_sh;
    logic                   r_carry;
    logic [CW-1:0]          r_cnt;
    logic [DATA_WIDTH-1:0]  r_sum;
    logic                   r_cout;
    logic                   r_ovf;
    logic                   r_zero;

    logic                   w_accept;
    logic                   w_last;
    logic [DIGIT_WIDTH-1:0] w_a_dig;
    logic [DIGIT_WIDTH-1:0] w_b_dig;
    logic [DIGIT_WIDTH:0]   w_dsum;
    logic                   w_c_msb;
    logic [DATA_WIDTH-1:0]  w_sum_shift;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)  w_state_next = S_RUN;
            S_RUN:   if (w_last)    w_state_next = S_OUT;
            S_OUT:   if (out_ready) w_state_next = S_IDLE;
            default:                w_state_next = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready  = (r_state == S_IDLE) && rst_n;
        out_valid = (r_state == S_OUT);
    end

    // ---------------- Datapath ----------------
    assign w_accept = in_valid & in_ready;
    assign w_last   = (r_state == S_RUN) && (r_cnt == LAST_DIG);
    assign w_a_dig  = r_a_sh[DIGIT_WIDTH-1:0];
    assign w_b_dig  = r_b_sh[DIGIT_WIDTH-1:0];
    assign w_dsum   = {1'b0, w_a_dig} + {1'b0, w_b_dig}
                    + {{DIGIT_WIDTH{1'b0}}, r_carry};

    // The carry into a digit's top bit is recovered from that bit's sum:
    // s = a ^ b ^ c  =>  c = a ^ b ^ s. On the final digit this is the carry
    // into the operand MSB, which works for any digit width.
    assign w_c_msb  = w_a_dig[DIGIT_WIDTH-1] ^ w_b_dig[DIGIT_WIDTH-1]
                    ^ w_dsum[DIGIT_WIDTH-1];

    // New digits enter from the MSB side. After NDIG shifts, digit 0 has
    // reached the bottom of the sum register.
    if (NDIG == 1) begin : g_single_digit
        assign w_sum_shift = w_dsum[DIGIT_WIDTH-1:0];
    end else begin : g_multi_digit
        assign w_sum_shift = {w_dsum[DIGIT_WIDTH-1:0], r_sum[DATA_WIDTH-1:DIGIT_WIDTH]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
        end else if (w_accept) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_carry <= cin;
            r_cnt   <= '0;
        end else if (r_state == S_RUN) begin
            r_a_sh  <= r_a_sh >> DIGIT_WIDTH;
            r_b_sh  <= r_b_sh >> DIGIT_WIDTH;
            r_carry <= w_dsum[DIGIT_WIDTH];
            r_cnt   <= r_cnt + CW'(1);
            r_sum   <= w_sum_shift;
            if (w_last) begin
                r_cout <= w_dsum[DIGIT_WIDTH];
                r_ovf  <= w_c_msb ^ w_dsum[DIGIT_WIDTH];
                r_zero <= (w_sum_shift == '0);
            end
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;
    assign zero = r_zero;

endmodule

// File: tb/tb_fa_serial_8.sv
// ---------------------------------------------------------------------------
// tb_fa_serial_8 : bench for fa_serial_8.
//
// Two instances share every input: the default (1-bit digits) and a 4-bit
// digit build. Each operation is issued to both at the same edge. Each result
// is compared against a + b + cin computed with plain integer arithmetic.
// ---------------------------------------------------------------------------
module tb_fa_serial_8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] a, b;
    logic       cin;
    logic       out_ready;

    logic       in_ready8, out_valid8, cout8, ovf8, zero8;
    logic [7:0] sum8;
    logic       in_ready4, out_valid4, cout4, ovf4, zero4;
    logic [7:0] sum4;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fa_serial_8 #(.DATA_WIDTH(8), .DIGIT_WIDTH(1)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready8),
        .a(a), .b(b), .cin(cin),
        .out_valid(out_valid8), .out_ready(out_ready),
        .sum(sum8), .cout(cout8), .ovf(ovf8), .zero(zero8)
    );

    fa_serial_8 #(.DATA_WIDTH(8), .DIGIT_WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready4),
        .a(a), .b(b), .cin(cin),
        .out_valid(out_valid4), .out_ready(out_ready),
        .sum(sum4), .cout(cout4), .ovf(ovf4), .zero(zero4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compares both instances' result outputs against the reference values.
    task automatic check_results(input string tag, input logic [7:0] e_sum,
                                 input logic e_cout, input logic e_ovf, input logic e_zero);
        check({tag, " valid8"}, out_valid8, 1'b1);
        check({tag, " valid4"}, out_valid4, 1'b1);
        check({tag, " in_ready8"}, in_ready8, 1'b0);
        check({tag, " in_ready4"}, in_ready4, 1'b0);
        check({tag, " sum8"},  sum8,  e_sum);
        check({tag, " cout8"}, cout8, e_cout);
        check({tag, " ovf8"},  ovf8,  e_ovf);
        check({tag, " zero8"}, zero8, e_zero);
        check({tag, " sum4"},  sum4,  e_sum);
        check({tag, " cout4"}, cout4, e_cout);
        check({tag, " ovf4"},  ovf4,  e_ovf);
        check({tag, " zero4"}, zero4, e_zero);
    endtask

    // One transaction. Operands are scrambled while both adders run, so the
    // results must come from the captured values. out_ready stays low for
    // bp_cycles after both results are up.
    task automatic do_op(input string tag, input logic [7:0] va, input logic [7:0] vb,
                         input logic vc, input int bp_cycles);
        logic [8:0] full;
        logic [7:0] e_sum;
        logic       e_cout, e_ovf, e_zero;
        int         lat8, lat4;

        full   = {1'b0, va} + {1'b0, vb} + {8'd0, vc};
        e_sum  = full[7:0];
        e_cout = full[8];
        e_ovf  = (va[7] == vb[7]) && (e_sum[7] != va[7]);
        e_zero = (e_sum == 8'd0);

        @(negedge clk);
        a = va; b = vb; cin = vc; in_valid = 1'b1; out_ready = 1'b0;
        check({tag, " in_ready8 idle"}, in_ready8, 1'b1);
        check({tag, " in_ready4 idle"}, in_ready4, 1'b1);
        @(negedge clk);                     // accept edge k has passed
        in_valid = 1'b0;
        check({tag, " in_ready8 run"}, in_ready8, 1'b0);

        lat8 = 0;
        lat4 = 0;
        for (int n = 1; n <= 20 && (lat8 == 0 || lat4 == 0); n++) begin
            a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
            @(negedge clk);
            if (out_valid8 && lat8 == 0) lat8 = n;
            if (out_valid4 && lat4 == 0) lat4 = n;
        end
        check({tag, " latency8"}, lat8, 8);
        check({tag, " latency4"}, lat4, 2);
        check_results(tag, e_sum, e_cout, e_ovf, e_zero);

        for (int i = 0; i < bp_cycles; i++) begin
            @(negedge clk);
            check_results({tag, " hold"}, e_sum, e_cout, e_ovf, e_zero);
        end

        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, " valid8 drop"}, out_valid8, 1'b0);
        check({tag, " valid4 drop"}, out_valid4, 1'b0);
        check({tag, " in_ready8 back"}, in_ready8, 1'b1);
        check({tag, " in_ready4 back"}, in_ready4, 1'b1);

        $display("%s: a=%02h b=%02h cin=%0d -> sum8=%02h sum4=%02h cout=%0d/%0d ovf=%0d/%0d lat=%0d/%0d",
                 tag, va, vb, vc, sum8, sum4, cout8, cout4, ovf8, ovf4, lat8, lat4);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = 8'd0; b = 8'd0; cin = 1'b0;
        repeat (2) @(negedge clk);
        check("reset in_ready8", in_ready8, 1'b0);
        check("reset valid8", out_valid8, 1'b0);
        check("reset sum8", sum8, 8'd0);
        check("reset flags8", {cout8, ovf8, zero8}, 3'b000);
        check("reset sum4", sum4, 8'd0);
        rst_n = 1'b1;

        do_op("basic",     8'h5A, 8'h3C, 1'b0, 0);
        do_op("wrap",      8'hFF, 8'h01, 1'b0, 0);
        do_op("allones",   8'hFF, 8'hFF, 1'b1, 0);
        do_op("cin_ovf",   8'h7F, 8'h00, 1'b1, 0);
        do_op("backpress", 8'hA5, 8'h5A, 1'b1, 5);
        do_op("dw4",       8'h9C, 8'h77, 1'b1, 0);

        // Reset pulse on RUN cycle 3 discards the operation.
        @(negedge clk);
        a = 8'h12; b = 8'h34; cin = 1'b0; in_valid = 1'b1;
        @(negedge clk);                     // accept edge k
        in_valid = 1'b0;
        repeat (2) @(negedge clk);          // edges k+1, k+2
        rst_n = 1'b0;
        #1;
        check("rst in_ready8 low", in_ready8, 1'b0);
        check("rst in_ready4 low", in_ready4, 1'b0);
        @(negedge clk);                     // edge k+3 applies reset
        rst_n = 1'b1;
        check("rst valid8", out_valid8, 1'b0);
        check("rst valid4", out_valid4, 1'b0);
        check("rst outs8", {sum8, cout8, ovf8, zero8}, 11'd0);
        check("rst outs4", {sum4, cout4, ovf4, zero4}, 11'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("rst no pulse", {out_valid8, out_valid4}, 2'b00);
        end
        do_op("after_rst", 8'h12, 8'h34, 1'b0, 0);

        for (int i = 0; i < 1000; i++) begin
            do_op("rand", 8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
